// File: rtl/parity_share_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parity_share_pkg
// Shared definitions for the parity-sharing controller:
//   - state_t   : controller FSM states
//   - NREQ_DEF  : default number of requesters
//   - DW_DEF    : default data word width
//   - rr_pick() : round-robin one-hot grant selection over up to 8 requesters
// -----------------------------------------------------------------------------
package parity_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;

    // Picks the first set bit of valid, starting at ptr and wrapping modulo n.
    // Width is fixed at 8 (the largest supported requester count); callers
    // zero-extend their request vector and pass the real count in n.
    function automatic logic [7:0] rr_pick(input logic [7:0]  valid,
                                           input logic [2:0]  ptr,
                                           input int unsigned n);
        logic [7:0]  grant;
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = (32'(ptr) + k) % n;
            if ((k < n) && !found && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/parity_serial_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parity_serial_core
// Bit-serial even-parity engine. A word is loaded, then each shift cycle the
// LSB is XORed into the accumulator and the register rotates right by one.
// Because the shifted-out bit re-enters at the MSB, after DW shifts the
// register holds the original word again, so data_out doubles as the
// "word that was processed" once the run is complete.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (clears register and acc)
//   load       in   load load_data and clear the accumulator
//   load_data  in   DW-bit word to process
//   shift_en   in   perform one serial parity step
//   parity_acc out  running XOR of the bits shifted so far
//   data_out   out  current shift register contents
// -----------------------------------------------------------------------------
module parity_serial_core #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          shift_en,
    output logic          parity_acc,
    output logic [DW-1:0] data_out
);

    logic [DW-1:0] sreg;
    logic          acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            acc  <= 1'b0;
        end else if (load) begin
            sreg <= load_data;
            acc  <= 1'b0;
        end else if (shift_en) begin
            acc  <= acc ^ sreg[0];
            sreg <= {sreg[0], sreg[DW-1:1]};
        end
    end

    assign parity_acc = acc;
    assign data_out   = sreg;

endmodule

// File: rtl/parity_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// parity_share_ctrl
// Shares one bit-serial even-parity engine between NREQ requesters. A
// round-robin arbiter grants one requester per IDLE cycle, the winner's word
// is shifted through the engine one bit per clock, and the parity bit is
// returned together with the requester ID and the word over a valid/ready
// response port.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NREQ]     per-requester request valid
//   req_data    in   [NREQ*DW]  requester i's word at bits [i*DW +: DW]
//   req_ready   out  [NREQ]     one-hot grant (only in IDLE)
//   rsp_valid   out  response valid (DONE state)
//   rsp_ready   in   consumer accepts response
//   rsp_id      out  [IDW]      index of the served requester
//   rsp_data    out  [DW]       word that was processed
//   rsp_parity  out  even-parity bit (XOR of all data bits)
//   busy        out  high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module parity_share_ctrl
    import parity_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_parity,
    output logic             busy
);

    localparam int CW = $clog2(DW);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    rr_ptr;
    logic [IDW-1:0] id_q;

    logic [7:0]    pick;
    logic [2:0]    sel_idx;
    logic [2:0]    next_ptr;
    logic          accept;
    logic [DW-1:0] sel_data;
    logic          core_load;
    logic          core_shift;
    logic          core_parity;
    logic [DW-1:0] core_data;

    // Arbitration: evaluated every cycle, only exposed while IDLE and out of
    // reset so req_ready reads zero while rst_n is asserted.
    assign pick = rr_pick(8'(req_valid), rr_ptr, NREQ);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (pick[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE)) req_ready = pick[NREQ-1:0];
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) sel_data = req_data[i*DW +: DW];
        end
    end

    always_comb begin
        if (sel_idx == 3'(NREQ - 1)) next_ptr = '0;
        else                         next_ptr = sel_idx + 3'd1;
    end

    // Controller FSM, bit counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rr_ptr  <= '0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        rr_ptr  <= next_ptr;
                        id_q    <= IDW'(sel_idx);
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    // The final XOR happens on this same edge in the core.
                    if (bit_cnt == CW'(DW - 1)) state <= DONE;
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_load  = (state == IDLE) && accept;
    assign core_shift = (state == SHIFT);

    parity_serial_core #(
        .DW (DW)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (core_load),
        .load_data  (sel_data),
        .shift_en   (core_shift),
        .parity_acc (core_parity),
        .data_out   (core_data)
    );

    // Core register has rotated back to the original word by the time DONE
    // is reached, so the response fields come straight from registers.
    assign rsp_valid  = (state == DONE);
    assign rsp_id     = id_q;
    assign rsp_data   = core_data;
    assign rsp_parity = core_parity;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_share_ctrl.sv
`timescale 1ns/1ps
module tb_parity_share_ctrl;

    logic        clk;
    logic        rst_n;

    // DUT A: NREQ=4, DW=8
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_parity;
    logic        busy;

    // DUT B: NREQ=1, DW=3
    logic [0:0]  b_req_valid;
    logic [2:0]  b_req_data;
    logic [0:0]  b_req_ready;
    logic        b_rsp_valid;
    logic        b_rsp_ready;
    logic [0:0]  b_rsp_id;
    logic [2:0]  b_rsp_data;
    logic        b_rsp_parity;
    logic        b_busy;

    parity_share_ctrl #(.NREQ(4), .DW(8), .IDW(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_parity (rsp_parity),
        .busy       (busy)
    );

    parity_share_ctrl #(.NREQ(1), .DW(3), .IDW(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_data   (b_req_data),
        .req_ready  (b_req_ready),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_id     (b_rsp_id),
        .rsp_data   (b_rsp_data),
        .rsp_parity (b_rsp_parity),
        .busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       par;
    } exp_a_t;

    typedef struct {
        logic [2:0] data;
        logic       par;
    } exp_b_t;

    exp_a_t qa[$];
    exp_b_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int resp_a   = 0;
    int resp_b   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on every accepted response
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected: got id %0h data %0h with no response expected", rsp_id, rsp_data);
            end else begin
                exp_a_t e;
                e = qa.pop_front();
                chk("a_rsp_id", 32'(rsp_id), 32'(e.id));
                chk("a_rsp_data", 32'(rsp_data), 32'(e.data));
                chk("a_rsp_parity", 32'(rsp_parity), 32'(e.par));
            end
            resp_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got data %0h with no response expected", b_rsp_data);
            end else begin
                exp_b_t e;
                e = qb.pop_front();
                chk("b_rsp_id", 32'(b_rsp_id), 32'd0);
                chk("b_rsp_data", 32'(b_rsp_data), 32'(e.data));
                chk("b_rsp_parity", 32'(b_rsp_parity), 32'(e.par));
            end
            resp_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic run_until(input int target, input string name);
        int n;
        n = 0;
        while (resp_a < target && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(resp_a), 32'(target));
    endtask

    logic [0:7] par3_tbl;
    int base;

    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        req_data    = '0;
        rsp_ready   = 1'b1;
        b_req_valid = 1'b1;
        b_req_data  = 3'd0;
        b_rsp_ready = 1'b1;
        par3_tbl    = 8'b0110_1001;

        // ---- reset state, requests pending while in reset
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_parity", 32'(rsp_parity), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_b_req_ready", 32'(b_req_ready), 32'd0);
        req_valid   = 4'b0000;
        b_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- test 1: single requester, latency and parity
        req_data  = {24'h0, 8'hA5};
        req_valid = 4'b0001;
        qa.push_back('{id: 2'd0, data: 8'hA5, par: 1'b0});
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t1_no_early_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("t1_valid_at_dw", 32'(rsp_valid), 32'd1);
        tick();
        chk("t1_valid_one_cycle", 32'(rsp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        req_data  = {24'h0, 8'h07};
        req_valid = 4'b0001;
        qa.push_back('{id: 2'd0, data: 8'h07, par: 1'b1});
        tick();
        req_valid = 4'b0000;
        wait_idle("t1b_done");

        // ---- test 2: all requesting, round-robin order from reset
        do_reset();
        req_data  = {8'h0F, 8'h07, 8'h03, 8'h01};
        req_valid = 4'b1111;
        qa.push_back('{id: 2'd0, data: 8'h01, par: 1'b1});
        qa.push_back('{id: 2'd1, data: 8'h03, par: 1'b0});
        qa.push_back('{id: 2'd2, data: 8'h07, par: 1'b1});
        qa.push_back('{id: 2'd3, data: 8'h0F, par: 1'b0});
        qa.push_back('{id: 2'd0, data: 8'h01, par: 1'b1});
        @(negedge clk);
        chk("t2_first_grant", 32'(req_ready), 32'h1);
        base = resp_a;
        run_until(base + 5, "t2_count");
        req_valid = 4'b0000;
        wait_idle("t2_done");

        // ---- test 3: pointer wrap past id 3
        do_reset();
        req_data  = {8'h00, 8'h33, 8'h00, 8'hFF};
        req_valid = 4'b0100;
        qa.push_back('{id: 2'd2, data: 8'h33, par: 1'b0});
        tick();
        req_valid = 4'b0000;
        wait_idle("t3_first");
        req_data[23:16] = 8'h80;
        req_valid = 4'b0101;
        qa.push_back('{id: 2'd0, data: 8'hFF, par: 1'b0});
        qa.push_back('{id: 2'd2, data: 8'h80, par: 1'b1});
        @(negedge clk);
        chk("t3_wrap_grant", 32'(req_ready), 32'h1);
        base = resp_a;
        run_until(base + 2, "t3_count");
        req_valid = 4'b0000;
        wait_idle("t3_done");

        // ---- test 4: backpressure in DONE
        rsp_ready = 1'b0;
        req_data  = {8'h00, 8'h00, 8'hFE, 8'h00};
        req_valid = 4'b0010;
        qa.push_back('{id: 2'd1, data: 8'hFE, par: 1'b1});
        tick();
        req_valid = 4'b1111;
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
        end
        chk("t4_reach_done", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_id", 32'(rsp_id), 32'd1);
            chk("t4_hold_data", 32'(rsp_data), 32'hFE);
            chk("t4_hold_parity", 32'(rsp_parity), 32'd1);
            chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
            chk("t4_hold_busy", 32'(busy), 32'd1);
        end
        base = resp_a;
        tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        chk("t4_idle_after_accept", 32'(busy), 32'd0);
        chk("t4_valid_dropped", 32'(rsp_valid), 32'd0);
        tick();
        chk("t4_single_accept", 32'(resp_a), 32'(base + 1));

        // ---- test 5: reset during SHIFT
        req_data  = {8'h5A, 8'h00, 8'h00, 8'h00};
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t5_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b1111;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("t5_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("t5_rst_rsp_parity", 32'(rsp_parity), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        qa.push_back('{id: 2'd0, data: 8'h00, par: 1'b0});
        @(negedge clk);
        chk("t5_ptr_cleared", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        wait_idle("t5_done");

        // ---- test 6: NREQ=1, DW=3 sweep
        for (int d = 0; d < 8; d++) begin
            b_req_data  = 3'(d);
            b_req_valid = 1'b1;
            qb.push_back('{data: 3'(d), par: par3_tbl[d]});
            @(negedge clk);
            chk("t6_req_ready", 32'(b_req_ready), 32'd1);
            tick();
            b_req_valid = 1'b0;
            tick();
            tick();
            chk("t6_no_early_valid", 32'(b_rsp_valid), 32'd0);
            tick();
            chk("t6_valid_at_dw", 32'(b_rsp_valid), 32'd1);
            tick();
        end
        tick();
        chk("t6_count", 32'(resp_b), 32'd8);

        tick();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_share_ctrl.md
Name: parity_share_ctrl

Overview:
Controller that shares one bit-serial even-parity engine between NREQ requesters.
- Arbitrates requests round-robin and latches the winner's DW-bit word.
- Shifts the word through the engine one bit per cycle, then returns the parity bit with the requester ID over a valid/ready response port.
- Sits between the producers of data words (for example, frame builders) and any consumer that needs even-parity bits.

Parameters:
NREQ, 4, number of requesters (1..8)
DW, 8, data word width in bits (2..32)
IDW, 2, width of requester ID; must be at least clog2(NREQ), minimum 1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*DW  packed words; requester i occupies bits [i*DW +: DW]
req_ready  out  NREQ  one-hot grant/accept
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  index of the served requester
rsp_data  out  DW  word that was processed
rsp_parity  out  1  even-parity bit: XOR of all data bits, so data plus parity has an even count of ones
busy  out  1  high whenever state is not IDLE

Behaviour:
Reset:
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous and active-low.
- While rst_n = 0, state = IDLE, rr_ptr = 0 and bit_cnt = 0. The shift register and accumulator are cleared.
- While rst_n = 0, all outputs are 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_parity, busy.

State machine (IDLE -> SHIFT -> DONE -> IDLE):
- IDLE:
  - req_ready is combinational and one-hot. It selects the first i with req_valid[i] = 1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready is all zeros when no request is valid.
  - On the edge where req_valid[i] & req_ready[i] = 1:
    - latch req_data[i] and i;
    - clear the accumulator and set bit_cnt = 0;
    - set rr_ptr = (i+1) mod NREQ;
    - go to SHIFT.
- SHIFT:
  - Each cycle, the LSB of the shift register is XORed into the accumulator, the register shifts right by one, and bit_cnt increments.
  - When bit_cnt = DW-1, go to DONE; the last XOR lands on that edge.
  - req_ready = 0.
- DONE:
  - rsp_valid = 1, and rsp_id, rsp_data and rsp_parity are registered and stable.
  - Hold until rsp_ready = 1, then go to IDLE on that edge.
  - req_ready = 0.

Latency:
- Handshake accepted on edge T; rsp_valid first high after edge T+DW.
- With rsp_ready held at 1, the next grant can be accepted on edge T+DW+2. Throughput is one word per DW+2 cycles.

Requester rules:
- Requesters hold req_valid and req_data stable until accepted.
- Deasserting req_valid before acceptance is permitted; that request is simply not served.

Boundary conditions:
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NREQ-1 grants.
- rr_ptr wraps from NREQ-1 to 0.
- NREQ = 1: the block degenerates to a single queue with req_ready[0] = 1 in IDLE.
- rsp_ready = 1 on entry to DONE: rsp_valid is high for exactly one cycle.
- Backpressure: DONE holds indefinitely and outputs do not change.
- rst_n asserted in any state: in-flight work is dropped and no response is produced.
- rsp_valid deasserts immediately on reset assertion.
- All-zero data gives parity 0; all-ones data gives parity DW mod 2.

Decomposition:
- Package parity_share_pkg holds:
  - the state enum (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2);
  - default constants NREQ_DEF = 4, DW_DEF = 8;
  - a function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module parity_serial_core:
  - ports clk, rst_n, load, load_data[DW], shift_en; outputs parity_acc and data_out[DW];
  - contains the shift register and XOR accumulator.
- The controller owns the FSM, bit counter and arbiter.

Test Plan:
1. NREQ=4, DW=8. req_valid = 4'b0001, data0 = 8'hA5.
   Response: rsp_valid after 8 clocks, rsp_id = 0, rsp_data = 8'hA5, rsp_parity = 0. Repeat with 8'h07: rsp_parity = 1.
2. All four valid with data 8'h01, 8'h03, 8'h07, 8'h0F, each held after service.
   Service order from reset: ids 0, 1, 2, 3, then 0 again. Parities 1, 0, 1, 0.
3. After serving id 2, req_valid = 4'b0101.
   Next grant is id 0 (wrap past 3), then id 2.
4. Hold rsp_ready = 0 for 5 cycles in DONE.
   rsp_* stable, req_ready = 0, busy = 1 throughout. rsp_ready = 1 gives one accept; IDLE on the next cycle.
5. Assert rst_n = 0 at bit_cnt = 4 in SHIFT.
   All outputs 0 immediately. After release, no stale response, and rr_ptr = 0 (id 0 wins a 4'b1111 request).
6. NREQ=1, DW=3, sweep data 0..7.
   rsp_parity = 0, 1, 1, 0, 1, 0, 0, 1, each after 3 shift clocks.
